// File: rtl/relu_bp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : relu_bp_pkg
//  Description : Shared definitions for the ReLU backprop gate: controller
//                state encoding and common IEEE-754 single-precision words.
//  Contents    : state_t   - controller states (3-bit encoding)
//                FLOAT_0   - +0.0 (value emitted for gated gradients)
//                FLOAT_1   - +1.0
//  Revision    : 1.0 - initial release
// ============================================================================
package relu_bp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CAPTURE  = 3'd1,
        ST_BACKWARD = 3'd2,
        ST_DRAIN    = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    localparam logic [31:0] FLOAT_0 = 32'h0000_0000;
    localparam logic [31:0] FLOAT_1 = 32'h3F80_0000;

endpackage : relu_bp_pkg
`default_nettype wire

// File: rtl/relu_mask_buf.sv
`default_nettype none
// ============================================================================
//  Module      : relu_mask_buf
//  Description : DEPTH x 1-bit register file holding the ReLU sign mask.
//                One synchronous write port, one asynchronous read port.
//                Storage has no reset; contents are only meaningful for
//                indices below the controller's entry count.
//  Ports       : clk        - clock
//                wr_en_i    - write strobe
//                wr_addr_i  - write index
//                wr_data_i  - mask bit (1 = forward input was negative)
//                rd_addr_i  - read index
//                rd_data_o  - mask bit at rd_addr_i (combinational)
//  Revision    : 1.0 - initial release
// ============================================================================
module relu_mask_buf
    import relu_bp_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic          wr_data_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic          rd_data_o
);

    logic [DEPTH-1:0] mem_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule : relu_mask_buf
`default_nettype wire

// File: rtl/relu_backprop_gate.sv
`default_nettype none
// ============================================================================
//  Module      : relu_backprop_gate
//  Description : ReLU backward-pass gate. The forward pass records one sign
//                bit per pre-activation; the backward pass replays the mask in
//                order, zeroing each upstream gradient whose forward input was
//                negative (including -0.0) and passing the others bit-exact.
//  Ports       : clk, rst                 - clock, async active-high reset
//                enable                   - global hold (0 freezes everything)
//                clear                    - synchronous abort to IDLE
//                fwd_valid/fwd_data/fwd_ready  - forward activation stream
//                start_bwd                - begin backward pass (pulse)
//                bwd_valid/bwd_grad/bwd_ready  - upstream gradient stream
//                out_valid/out_grad/out_ready  - gated gradient stream
//                count                    - mask entries stored
//                busy / done / err        - status (done, err are pulses)
//  Revision    : 1.0 - initial release
// ============================================================================
module relu_backprop_gate
    import relu_bp_pkg::*;
#(
    parameter int BITWIDTH = 32,
    parameter int DEPTH    = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic                         clear,
    input  logic                         fwd_valid,
    input  logic [BITWIDTH-1:0]          fwd_data,
    output logic                         fwd_ready,
    input  logic                         start_bwd,
    input  logic                         bwd_valid,
    input  logic [BITWIDTH-1:0]          bwd_grad,
    output logic                         bwd_ready,
    output logic                         out_valid,
    output logic [BITWIDTH-1:0]          out_grad,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         busy,
    output logic                         done,
    output logic                         err
);

    localparam int BW = BITWIDTH - 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CW-1:0]       DEPTH_C   = CW'(DEPTH);
    localparam logic [CW-1:0]       ONE_C     = CW'(1);
    localparam logic [BITWIDTH-1:0] ZERO_GRAD = BITWIDTH'(FLOAT_0);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                state_q,     state_d;
    logic [CW-1:0]         count_q,     count_d;
    logic [CW-1:0]         rd_idx_q,    rd_idx_d;
    logic                  out_valid_q, out_valid_d;
    logic [BITWIDTH-1:0]   out_grad_q,  out_grad_d;
    logic                  done_q,      done_d;
    logic                  err_q,       err_d;

    logic                  w_fwd_acc;
    logic                  w_bwd_acc;
    logic                  w_mask_bit;
    logic                  w_fwd_payload_unused;

    // Only the sign of a forward word matters; the remaining payload bits
    // are folded into a deliberately dangling net.
    assign w_fwd_payload_unused = ^fwd_data[BW-1:0];

    // ------------------------------------------------------------------
    // Handshakes (combinational from state/count)
    // ------------------------------------------------------------------
    always_comb begin
        fwd_ready = 1'b0;
        if (enable) begin
            if (state_q == ST_IDLE) begin
                fwd_ready = 1'b1;
            end else if (state_q == ST_CAPTURE) begin
                fwd_ready = (count_q < DEPTH_C);
            end
        end
    end

    // Single output register: a new gradient may enter whenever the
    // register is empty or is being emptied this cycle.
    assign bwd_ready = enable && (state_q == ST_BACKWARD) &&
                       (!out_valid_q || out_ready);

    assign w_fwd_acc = fwd_valid && fwd_ready;
    assign w_bwd_acc = bwd_valid && bwd_ready;
    assign busy      = (state_q != ST_IDLE);

    // ------------------------------------------------------------------
    // Mask storage: written at the current count, read at rd_idx
    // ------------------------------------------------------------------
    relu_mask_buf #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mask_buf (
        .clk       (clk),
        .wr_en_i   (w_fwd_acc),
        .wr_addr_i (count_q[AW-1:0]),
        .wr_data_i (fwd_data[BW]),
        .rd_addr_i (rd_idx_q[AW-1:0]),
        .rd_data_o (w_mask_bit)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        rd_idx_d    = rd_idx_q;
        out_valid_d = out_valid_q;
        out_grad_d  = out_grad_q;
        done_d      = 1'b0;
        err_d       = 1'b0;

        if (clear) begin
            state_d     = ST_IDLE;
            count_d     = '0;
            rd_idx_d    = '0;
            out_valid_d = 1'b0;
            out_grad_d  = '0;
        end else if (enable) begin
            // A forward beat offered but refused is always an error: either
            // the buffer is full or the pass has moved past capture.
            if ((fwd_valid && !fwd_ready) ||
                ((state_q == ST_IDLE) && start_bwd)) begin
                err_d = 1'b1;
            end

            if (w_fwd_acc) begin
                count_d = count_q + ONE_C;
            end

            if (out_valid_q && out_ready) begin
                out_valid_d = 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (w_fwd_acc) begin
                        state_d = ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    // A beat accepted in this same cycle is already counted
                    // above, so it participates in the backward pass.
                    if (start_bwd) begin
                        state_d  = ST_BACKWARD;
                        rd_idx_d = '0;
                    end
                end
                ST_BACKWARD: begin
                    if (w_bwd_acc) begin
                        out_valid_d = 1'b1;
                        out_grad_d  = w_mask_bit ? ZERO_GRAD : bwd_grad;
                        rd_idx_d    = rd_idx_q + ONE_C;
                        if (rd_idx_q == (count_q - ONE_C)) begin
                            state_d = ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!out_valid_q || out_ready) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            rd_idx_q    <= '0;
            out_valid_q <= 1'b0;
            out_grad_q  <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rd_idx_q    <= rd_idx_d;
            out_valid_q <= out_valid_d;
            out_grad_q  <= out_grad_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_grad  = out_grad_q;
    assign count     = count_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule : relu_backprop_gate
`default_nettype wire

// File: doc/relu_backprop_gate.md
RELU_BACKPROP_GATE -- requirements
Module: relu_backprop_gate

Interface
REQ-001 Parameter BITWIDTH, default 32, IEEE-754 word width; BW = BITWIDTH-1.
REQ-002 Parameter DEPTH, default 64, mask buffer entries; CW = $clog2(DEPTH+1).
REQ-003 clk  input  1  clock, all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 enable  input  1  global hold; 0 freezes all state, forces fwd_ready/bwd_ready to 0.
REQ-006 clear  input  1  synchronous abort to IDLE.
REQ-007 fwd_valid / fwd_data / fwd_ready  in/in/out  1/BITWIDTH/1  forward pre-activation stream.
REQ-008 start_bwd  input  1  single-cycle request to begin the backward pass.
REQ-009 bwd_valid / bwd_grad / bwd_ready  in/in/out  1/BITWIDTH/1  incoming upstream gradient stream.
REQ-010 out_valid / out_grad / out_ready  out/out/in  1/BITWIDTH/1  gated gradient stream.
REQ-011 count  output  CW  mask entries stored.
REQ-012 busy / done / err  output  1 each  state != IDLE / one-cycle end pulse / one-cycle error pulse.

Function
REQ-013 FSM states: IDLE, CAPTURE, BACKWARD, DRAIN, DONE.
REQ-014 Forward beat accepted when fwd_valid && fwd_ready; stores mask bit fwd_data[BW] (1 = negative, incl. -0.0) at index count; count increments.
REQ-015 fwd_ready = 1 in IDLE, = (count < DEPTH) in CAPTURE, 0 elsewhere.
REQ-016 IDLE -> CAPTURE on first accepted forward beat.
REQ-017 CAPTURE -> BACKWARD on start_bwd; read index rd_idx reset to 0; a forward beat accepted in the same cycle is stored and counted first.
REQ-018 start_bwd in IDLE (count = 0): stay IDLE, err pulse.
REQ-019 fwd_valid while full (count = DEPTH) not accepted; err pulses each such cycle; no overwrite.
REQ-020 BACKWARD: bwd_ready = !out_valid || out_ready (single output register, full throughput).
REQ-021 Accepted gradient: out_grad = 32'h00000000 if mask[rd_idx] = 1, else bwd_grad bit-exact; out_valid next cycle; rd_idx increments. Latency exactly 1 cycle.
REQ-022 out_valid/out_grad held stable while out_valid && !out_ready.
REQ-023 Acceptance of gradient with rd_idx = count-1 -> DRAIN; bwd_ready = 0 in DRAIN.
REQ-024 DRAIN -> DONE when output register empties (last beat taken, or same-cycle out_ready).
REQ-025 DONE: done = 1 for exactly one cycle, count cleared, next state IDLE.
REQ-026 fwd_valid asserted in BACKWARD/DRAIN/DONE: not accepted, err pulse.
REQ-027 bwd_valid outside BACKWARD ignored, no err.
REQ-028 clear: highest priority after rst; next cycle state IDLE, count = 0, rd_idx = 0, out_valid = 0, in-flight output dropped, no done.
REQ-029 enable = 0: no state, count, mask or output change; done/err forced 0; resumes exactly where frozen.

Reset
REQ-030 rst asserted: state IDLE, count 0, rd_idx 0, out_valid 0, out_grad 0, done 0, err 0, busy 0, mask contents don't-care.
REQ-031 rst mid-BACKWARD discards pass; after deassertion fwd_ready = 1 in first cycle.

Structure
REQ-032 Shared package relu_bp_pkg: state enum, FLOAT_0 (32'h00000000), FLOAT_1 (32'h3F800000).
REQ-033 Sub-module relu_mask_buf: DEPTH x 1-bit register file, one write port, one async read port, no reset on storage.
REQ-034 All outputs registered except fwd_ready, bwd_ready, busy (combinational from state/count).

Verification
REQ-035 4 fwd beats {3F800000, BF800000, 40000000, 80000000}, start_bwd, 4 grads of 3F000000, out_ready=1 -> outputs 3F000000, 00000000, 3F000000, 00000000, each 1 cycle after accept; done one cycle later.
REQ-036 out_ready=0 for 3 cycles mid-backward -> out_grad stable, bwd_ready=0, no beat lost or duplicated.
REQ-037 DEPTH=4, 6 fwd beats offered -> 4 stored, count=4, err pulses on each refused cycle, fwd_ready=0.
REQ-038 start_bwd with count=0 -> err=1 one cycle, busy=0.
REQ-039 clear during BACKWARD after 2 of 4 grads -> next cycle IDLE, out_valid=0, count=0, no done.
REQ-040 rst asserted asynchronously mid-DRAIN -> all outputs zero immediately; new 1-beat pass completes correctly.
